// File: rtl/aes_cipher_round_if.sv
// Block-level bus for aes_cipher_round: plaintext/start in, state/ready out.
interface aes_cipher_round_if;
   logic [15:0][7:0] Data_in;
   logic             Enable;
   logic [15:0][7:0] Data_out;
   logic             Ready_out;

   modport master (output Data_in, output Enable, input Data_out, input Ready_out);
   modport slave  (input Data_in, input Enable, output Data_out, output Ready_out);
endinterface

// File: rtl/aes_cipher_round.sv
// Iterative AES encryption core: one round per clock under a round counter,
// with GF(2^8) arithmetic done through externally supplied S-box and log/antilog tables.
module aes_cipher_round #(
   parameter int unsigned NB = 4,
   parameter int unsigned NR = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [255:0][7:0]          SBox,
   input  logic [255:0][7:0]          EXP3,
   input  logic [255:0][7:0]          LN3,
   input  logic [NB*(NR+1)-1:0][31:0] KExp,
   aes_cipher_round_if.slave          bus
);
   localparam int unsigned NBYTES = 4 * NB;

   typedef enum logic [1:0] {PH_IDLE, PH_ROUND, PH_FINAL} phase_t;

   logic [NBYTES-1:0][7:0] r_state;
   logic [3:0]             r_round;
   logic                   r_ready;

   phase_t                 w_phase;
   logic [3:0]             w_round_nxt;
   logic [3:0]             w_rnd;
   logic                   w_ready_nxt;
   logic [NBYTES-1:0][7:0] w_sub;
   logic [NBYTES-1:0][7:0] w_shift;
   logic [NBYTES-1:0][7:0] w_x2;
   logic [NBYTES-1:0][7:0] w_x3;
   logic [NBYTES-1:0][7:0] w_mix;
   logic [NBYTES-1:0][7:0] w_ark_in;
   logic [NBYTES-1:0][7:0] w_state_nxt;

   function automatic logic [7:0] mod255(input logic [8:0] s);
      logic [8:0] t;
      t = (s >= 9'd255) ? s - 9'd255 : s;
      return t[7:0];
   endfunction

   // SubBytes -> ShiftRows -> MixColumns, purely combinational from the state register
   always_comb begin
      w_sub   = '0;
      w_shift = '0;
      w_x2    = '0;
      w_x3    = '0;
      w_mix   = '0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         w_sub[i] = SBox[r_state[i]];
      end
      for (int unsigned c = 0; c < NB; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            w_shift[4*c+r] = w_sub[4*((c+r)%4)+r];
         end
      end
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (w_shift[i] != 8'h00) begin
            w_x2[i] = EXP3[mod255({1'b0, LN3[w_shift[i]]} + {1'b0, LN3[8'h02]})];
            w_x3[i] = EXP3[mod255({1'b0, LN3[w_shift[i]]} + {1'b0, LN3[8'h03]})];
         end
      end
      for (int unsigned c = 0; c < NB; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            w_mix[4*c+r] = w_x2[4*c+r] ^ w_x3[4*c+(r+1)%4]
                         ^ w_shift[4*c+(r+2)%4] ^ w_shift[4*c+(r+3)%4];
         end
      end
   end

   // Counts above NR cannot occur normally; treating them as Idle keeps KExp indexing in range
   always_comb begin
      if (r_round == 4'(NR))
         w_phase = PH_FINAL;
      else if (r_round == 4'd0 || r_round > 4'(NR))
         w_phase = PH_IDLE;
      else
         w_phase = PH_ROUND;
   end

   always_comb begin
      w_round_nxt = '0;
      w_ready_nxt = 1'b0;
      w_rnd       = '0;
      w_ark_in    = bus.Data_in;
      unique case (w_phase)
         PH_IDLE:  w_round_nxt = bus.Enable ? 4'd1 : 4'd0;
         PH_ROUND: begin
            w_round_nxt = r_round + 4'd1;
            w_rnd       = r_round;
            w_ark_in    = w_mix;
         end
         PH_FINAL: begin
            w_rnd       = r_round;
            w_ark_in    = w_shift;
            w_ready_nxt = 1'b1;
         end
         default: ;
      endcase
      w_state_nxt = '0;
      for (int unsigned c = 0; c < NB; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            w_state_nxt[4*c+r] = w_ark_in[4*c+r] ^ KExp[4*w_rnd+c][31-8*r -: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      r_state <= w_state_nxt;
      if (!rst) begin
         r_round <= '0;
         r_ready <= 1'b0;
      end else begin
         r_round <= w_round_nxt;
         r_ready <= w_ready_nxt;
      end
   end

   assign bus.Data_out  = r_state;
   assign bus.Ready_out = r_ready;
endmodule

// File: tb/tb_aes_cipher_round.sv
// Scoreboard bench for aes_cipher_round: NR=10 and NR=14 instances driven with
// FIPS-197 / SP800-38A vectors; a per-instance monitor checks every Ready pulse.
module tb_aes_cipher_round;
   typedef struct {
      logic [127:0] ct;
      int           cyc;
   } sb_t;

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] ARK0_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_S1  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] CT_S1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] PT_S2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] CT_S2  = 128'hf5d3d58503b9699de785895a96fdbaaf;

   logic              clk = 1'b0;
   logic              rst;
   logic [255:0][7:0] sbox_tab;
   logic [255:0][7:0] exp_tab;
   logic [255:0][7:0] ln_tab;
   logic [43:0][31:0] k10;
   logic [59:0][31:0] k14;
   logic [59:0][31:0] wtmp;
   int                cyc = 0;
   int                total = 0;
   int                bad = 0;
   sb_t               q10[$];
   sb_t               q14[$];
   sb_t               e10;
   sb_t               e14;
   sb_t               eb;

   aes_cipher_round_if if10();
   aes_cipher_round_if if14();

   aes_cipher_round #(.NB(4), .NR(10)) dut10 (
      .clk(clk), .rst(rst), .SBox(sbox_tab), .EXP3(exp_tab), .LN3(ln_tab),
      .KExp(k10), .bus(if10)
   );
   aes_cipher_round #(.NB(4), .NR(14)) dut14 (
      .clk(clk), .rst(rst), .SBox(sbox_tab), .EXP3(exp_tab), .LN3(ln_tab),
      .KExp(k14), .bus(if14)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
   endfunction

   function automatic logic [15:0][7:0] to_bytes(input logic [127:0] h);
      logic [15:0][7:0] r;
      for (int i = 0; i < 16; i++) r[i] = h[127-8*i -: 8];
      return r;
   endfunction

   function automatic logic [127:0] from_bytes(input logic [15:0][7:0] b);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
      return r;
   endfunction

   task automatic build_tables();
      logic [7:0] e;
      logic [7:0] inv;
      e = 8'h01;
      for (int i = 0; i < 255; i++) begin
         exp_tab[i] = e;
         ln_tab[e]  = 8'(i);
         e = e ^ xtime(e);
      end
      exp_tab[255] = 8'h01;
      ln_tab[0]    = 8'h00;
      for (int x = 0; x < 256; x++) begin
         inv = (x == 0) ? 8'h00 : exp_tab[(255 - int'(ln_tab[x])) % 255];
         sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic key_expand(input logic [255:0] key, input int nk, input int nr,
                             output logic [59:0][31:0] w);
      logic [31:0] t;
      logic [7:0]  rc;
      w  = '0;
      rc = 8'h01;
      for (int i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) begin
            w[i] = key[255-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
               t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
   endtask

   task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic chkint(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input int which, input logic [127:0] pt, input logic [127:0] ct);
      sb_t e;
      e.ct = ct;
      if (which == 14) begin
         if14.Data_in = to_bytes(pt);
         if14.Enable  = 1'b1;
         e.cyc = cyc + 15;
         q14.push_back(e);
      end else begin
         if10.Data_in = to_bytes(pt);
         if10.Enable  = 1'b1;
         e.cyc = cyc + 11;
         q10.push_back(e);
      end
      tick(1);
      if10.Enable = 1'b0;
      if14.Enable = 1'b0;
   endtask

   always @(negedge clk) begin
      if (if10.Ready_out === 1'b1) begin
         if (q10.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ready10_spurious: Ready_out=1 at cycle %0d, required 0", cyc);
         end else begin
            e10 = q10.pop_front();
            chk128("ct10", from_bytes(if10.Data_out), e10.ct);
            chkint("ready10_cycle", cyc, e10.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (if14.Ready_out === 1'b1) begin
         if (q14.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ready14_spurious: Ready_out=1 at cycle %0d, required 0", cyc);
         end else begin
            e14 = q14.pop_front();
            chk128("ct14", from_bytes(if14.Data_out), e14.ct);
            chkint("ready14_cycle", cyc, e14.cyc);
         end
      end
   end

   initial begin
      build_tables();
      rst = 1'b0;
      if10.Enable  = 1'b0;
      if14.Enable  = 1'b0;
      if10.Data_in = '0;
      if14.Data_in = '0;
      key_expand({KEY_B, 128'h0}, 4, 10, wtmp);
      k10 = wtmp[43:0];
      key_expand(KEY_C3, 8, 14, wtmp);
      k14 = wtmp;
      tick(3);
      chk1("reset_ready10", if10.Ready_out, 1'b0);
      chk1("reset_ready14", if14.Ready_out, 1'b0);
      rst = 1'b1;
      tick(2);

      // FIPS-197 App. B, then the Idle overwrite with round-0 AddRoundKey
      issue(10, PT_B, CT_B);
      tick(11);
      chk128("idle_ark0", from_bytes(if10.Data_out), ARK0_B);

      key_expand({KEY_C1, 128'h0}, 4, 10, wtmp);
      k10 = wtmp[43:0];
      issue(10, PT_C, CT_C1);
      tick(11);

      // back-to-back with Enable held through the Ready cycle
      key_expand({KEY_B, 128'h0}, 4, 10, wtmp);
      k10 = wtmp[43:0];
      if10.Data_in = to_bytes(PT_S1);
      if10.Enable  = 1'b1;
      eb.ct = CT_S1; eb.cyc = cyc + 11; q10.push_back(eb);
      eb.ct = CT_S2; eb.cyc = cyc + 22; q10.push_back(eb);
      tick(1);
      if10.Data_in = to_bytes(PT_S2);
      tick(11);
      if10.Enable = 1'b0;
      tick(11);

      // Enable and Data_in wiggled during rounds 1..NR
      key_expand({KEY_C1, 128'h0}, 4, 10, wtmp);
      k10 = wtmp[43:0];
      if10.Data_in = to_bytes(PT_C);
      if10.Enable  = 1'b1;
      eb.ct = CT_C1; eb.cyc = cyc + 11; q10.push_back(eb);
      tick(1);
      for (int k = 1; k <= 10; k++) begin
         if10.Enable  = (k % 3 != 0);
         if10.Data_in = to_bytes({$urandom, $urandom, $urandom, $urandom});
         tick(1);
      end
      if10.Enable  = 1'b0;
      if10.Data_in = to_bytes(PT_C);
      tick(2);

      // reset during round 5 aborts the block
      key_expand({KEY_B, 128'h0}, 4, 10, wtmp);
      k10 = wtmp[43:0];
      if10.Data_in = to_bytes(PT_B);
      if10.Enable  = 1'b1;
      tick(1);
      if10.Enable = 1'b0;
      tick(4);
      rst = 1'b0;
      tick(1);
      chk1("midreset_ready10", if10.Ready_out, 1'b0);
      rst = 1'b1;
      tick(13);
      chk1("abort_ready10", if10.Ready_out, 1'b0);
      issue(10, PT_B, CT_B);
      tick(11);

      // AES-256, FIPS-197 C.3
      issue(14, PT_C, CT_C3);
      tick(16);

      tick(3);
      chkint("q10_drained", q10.size(), 0);
      chkint("q14_drained", q14.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/aes_cipher_round.md
AES_CIPHER_ROUND -- requirements
Module: aes_cipher_round

Interface
REQ-001 Parameter NB, default 4, state width in 32-bit columns; only 4 is supported.
REQ-002 Parameter NR, default 10, number of rounds; supported values are 10, 12 and 14.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset: synchronous, active-low.
REQ-005 SBox  input  256 x 8  forward S-box table, indexed by byte value.
REQ-006 EXP3  input  256 x 8  GF(2^8) antilog table, base 0x03.
REQ-007 LN3  input  256 x 8  GF(2^8) log table, base 0x03; entry 0 is don't-care.
REQ-008 KExp  input  NB*(NR+1) x 32  expanded key schedule; word 4*rnd+c is the round-rnd key for column c, with row 0 in bits [31:24].
REQ-009 Data_in  input  16 x 8  plaintext state; byte index = 4*col + row (FIPS-197 input order).
REQ-010 Enable  input  1  start request, sampled while Idle.
REQ-011 Data_out  output  16 x 8  contents of the state register.
REQ-012 Ready_out  output  1  one-cycle pulse marking Data_out as the ciphertext.

Function
REQ-013 Controller SHALL hold a 4-bit round counter: 0 = Idle, 1..NR-1 = full rounds, NR = final round.
REQ-014 Idle: next state register = AddRoundKey(Data_in, round 0); counter goes to 1 if Enable=1, else stays 0; next ready = 0.
REQ-015 Rounds 1..NR-1: next state = AddRoundKey(MixColumns(ShiftRows(SubBytes(S))), round = counter), where S is the state register; counter increments; next ready = 0.
REQ-016 Round NR: next state = AddRoundKey(ShiftRows(SubBytes(S)), round NR), with no MixColumns; counter goes to 0; next ready = 1.
REQ-017 The state register SHALL load every cycle in every state; Data_out SHALL equal the state register.
REQ-018 Ready_out SHALL be the registered ready bit, high for exactly the one Idle cycle after round NR.
REQ-019 Latency: with Enable=1 sampled in Idle cycle T, Ready_out=1 and the ciphertext is on Data_out in cycle T+NR+1.
REQ-020 Ciphertext is valid only in the Ready cycle; on the next edge Idle overwrites it with AddRoundKey(Data_in, 0).
REQ-021 Enable=1 in the Ready cycle SHALL start a new block with no bubble; Enable during rounds 1..NR SHALL be ignored.
REQ-022 SubBytes: out[i] = SBox[in[i]] for all 16 bytes.
REQ-023 ShiftRows: out[4c+r] = in[4((c+r) mod 4)+r].
REQ-024 MixColumns: per column, out0=2a0^3a1^a2^a3, out1=a0^2a1^3a2^a3, out2=a0^a1^2a2^3a3, out3=3a0^a1^a2^2a3.
REQ-025 MixColumns multiplication is over GF(2^8) mod 0x11B: x*y = EXP3[(LN3[x]+LN3[y]) mod 255], and the product SHALL be 0 when either operand is 0.
REQ-026 AddRoundKey: out[4c+r] = in[4c+r] XOR KExp[4*rnd+c][31-8r -: 8].
REQ-027 Datapath SHALL be combinational between the state register and its next-state input; one round per cycle.

Reset
REQ-028 With rst=0 at a clock edge: counter <= 0 (Idle) and ready <= 0, so Ready_out=0 from the next cycle.
REQ-029 The state register SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL abort the block: no Ready pulse follows, and the unit is in Idle after release.

Verification
REQ-031 FIPS-197 App. B, NR=10: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, Enable pulse -> Ready_out high 11 cycles later with Data_out=3925841d02dc09fbdc118597196a0b32.
REQ-032 FIPS-197 C.1: key 000102...0f, plaintext 00112233445566778899aabbccddeeff -> Data_out=69c4e0d86a7b0430d8cdb78070b4c55a on the Ready cycle.
REQ-033 Back-to-back: Enable held high through the Ready cycle with a new plaintext -> second correct ciphertext exactly 11 cycles after the first Ready.
REQ-034 Enable toggled during rounds 1..NR -> no effect on the result or timing; Ready_out is a single-cycle pulse only.
REQ-035 Reset asserted at round 5 -> Ready_out stays 0; a subsequent Enable yields the correct ciphertext.
REQ-036 NR=14 with the FIPS-197 C.3 key -> Data_out=8ea2b7ca516745bfeafc49904b496089, Ready_out high 15 cycles after Enable.
